// File: rtl/sync_pulse_arbiter.sv
// Round-robin scheduler that shares one pulse-crossing channel between N requesters.
// Optional macro SYNC_PULSE_ARBITER_PEND_COUNT_EN: per-requester request counters instead of single pending bits.
module sync_pulse_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4,
  parameter int CNTW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           busy,
  output logic           sig_out,
  output logic [IDW-1:0] id_out,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   pending,
  output logic           idle,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, WAIT_ASSERT, WAIT_DONE} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] ptr;
  logic [TW-1:0]  wd, wd_nx;
  logic [IDW-1:0] winner;
  logic           found;
  logic           issue;
  logic           err_set;

`ifdef SYNC_PULSE_ARBITER_PEND_COUNT_EN
  logic [CNTW-1:0] cnt [N];

  for (genvar i = 0; i < N; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[i] <= '0;
      end else begin
        case ({req[i], grant[i]})
          2'b10:   if (cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
          2'b01:   if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
    assign pending[i] = (cnt[i] != '0);
  end
`else
  // A request landing in the same cycle as its grant keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= req | (pending & ~grant);
  end
`endif

  // First pending requester after the last winner, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && pending[(int'(ptr) + k) % N]) begin
        found  = 1'b1;
        winner = IDW'((int'(ptr) + k) % N);
      end
    end
  end

  always_comb begin
    state_nx = state;
    wd_nx    = wd;
    issue    = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (found && !busy) begin
          issue    = 1'b1;
          wd_nx    = '0;
          state_nx = WAIT_ASSERT;
        end
      end
      WAIT_ASSERT: begin
        if (busy) begin
          state_nx = WAIT_DONE;
        end else begin
          wd_nx = wd + 1'b1;
          if (wd_nx == TW'(TIMEOUT)) begin
            err_set  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        // Round trip depends on the far clock, so no watchdog here.
        if (!busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wd      <= '0;
      ptr     <= IDW'(N - 1);
      id_out  <= '0;
      grant   <= '0;
      sig_out <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      wd      <= wd_nx;
      sig_out <= issue;
      grant   <= issue ? (N'(1) << winner) : '0;
      err     <= err | err_set;
      if (issue) begin
        id_out <= winner;
        ptr    <= winner;
      end
    end
  end

  assign idle = (state == IDLE) && !(|pending);

endmodule

// File: tb/tb_sync_pulse_arbiter.sv
// Bench for sync_pulse_arbiter: model crossing channel plus an expected-ID scoreboard.
module tb_sync_pulse_arbiter;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       busy = 1'b0;
  logic       sig_out;
  logic [1:0] id_out;
  logic [3:0] grant;
  logic [3:0] pending;
  logic       idle;
  logic       err;

  int checks = 0;
  int errors = 0;
  int crossings = 0;
  int q[$];
  int mon_id;
  logic [3:0] mon_grant;
  bit chan_en = 1'b1;
  bit busy_force = 1'b0;
  int bcnt = 0;

  sync_pulse_arbiter #(.N(4), .IDW(2), .TIMEOUT(TIMEOUT), .TW(4), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .sig_out(sig_out),
    .id_out(id_out), .grant(grant), .pending(pending), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  // Channel model: busy rises one cycle after sig_out and stays high for 6 cycles.
  always @(posedge clk) begin
    #2;
    if (!chan_en) begin
      bcnt = 0;
      busy = busy_force;
    end else begin
      if (bcnt > 0) begin
        busy = 1'b1;
        bcnt--;
      end else begin
        busy = busy_force;
      end
      if (sig_out) bcnt = 6;
    end
  end

  // Scoreboard: each crossing must match the oldest expected ID.
  always @(negedge clk) begin
    if (rst_n && sig_out) begin
      crossings++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_crossing id_out=%0d required no crossing", id_out);
      end else begin
        mon_id = q.pop_front();
        mon_grant = 4'b0001 << mon_id;
        if (id_out !== 2'(mon_id)) begin
          errors++;
          $display("FAIL crossing_id id_out=%0d required %0d", id_out, mon_id);
        end
        checks++;
        if (grant !== mon_grant) begin
          errors++;
          $display("FAIL crossing_grant grant=%b required %b", grant, mon_grant);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL sig_overlaps_busy busy=%b required 0", busy);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q.delete();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (n < budget && !(q.size() == 0 && idle && !busy && bcnt == 0)) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain outstanding=%0d idle=%b required 0 and 1", name, q.size(), idle);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    #3;
    checks++;
    if ({sig_out, grant, id_out, pending, err, idle} !== {1'b0, 4'b0, 2'b0, 4'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values sig=%b grant=%b id=%0d pend=%b err=%b idle=%b required 0 0000 0 0000 0 1",
               sig_out, grant, id_out, pending, err, idle);
    end
    do_reset();
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    c0 = crossings;
    req = 4'b0001;
    q.push_back(0);
    @(negedge clk);
    req = '0;
    checks++;
    if (pending !== 4'b0001 || sig_out !== 1'b0) begin
      errors++;
      $display("FAIL single_latency pending=%b sig=%b required 0001 0", pending, sig_out);
    end
    wait_drain(100, "single");
    checks++;
    if (crossings - c0 != 1) begin
      errors++;
      $display("FAIL single_count crossings=%0d required 1", crossings - c0);
    end
  endtask

  task automatic test_all();
    int c0;
    do_reset();
    c0 = crossings;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) q.push_back(i);
    @(negedge clk);
    req = '0;
    wait_drain(200, "all");
    checks++;
    if (crossings - c0 != 4) begin
      errors++;
      $display("FAIL all_count crossings=%0d required 4", crossings - c0);
    end
    checks++;
    if (id_out !== 2'd3) begin
      errors++;
      $display("FAIL all_id_hold id_out=%0d required 3", id_out);
    end
  endtask

  task automatic test_same_cycle();
    int c0;
    int n = 0;
    do_reset();
    c0 = crossings;
    req = 4'b0100;
    q.push_back(2);
    @(negedge clk);
    req = '0;
    while (grant[2] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (grant[2] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_grant grant=%b required 0100", grant);
    end
    req = 4'b0100;
    q.push_back(2);
    @(negedge clk);
    req = '0;
    checks++;
    if (pending[2] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_pending pending=%b required bit2 set", pending);
    end
    wait_drain(100, "same_cycle");
    checks++;
    if (crossings - c0 != 2) begin
      errors++;
      $display("FAIL same_cycle_count crossings=%0d required 2", crossings - c0);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    chan_en = 1'b0;
    req = 4'b0001;
    q.push_back(0);
    @(negedge clk);
    req = '0;
    while (sig_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early err=%b required 0", err);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || idle !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err err=%b idle=%b required 1 1", err, idle);
    end
    chan_en = 1'b1;
    req = 4'b0010;
    q.push_back(1);
    @(negedge clk);
    req = '0;
    wait_drain(100, "after_timeout");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky err=%b required 1", err);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    req = 4'b0111;
    q.push_back(0);
    @(negedge clk);
    req = '0;
    while (!(busy === 1'b1 && pending === 4'b0110) && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || pending !== 4'b0110) begin
      errors++;
      $display("FAIL reset_mid_setup busy=%b pending=%b required 1 0110", busy, pending);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({sig_out, grant, id_out, pending, err, idle} !== {1'b0, 4'b0, 2'b0, 4'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_values sig=%b grant=%b id=%0d pend=%b err=%b idle=%b required 0 0000 0 0000 0 1",
               sig_out, grant, id_out, pending, err, idle);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0100;
    q.push_back(2);
    @(negedge clk);
    req = '0;
    wait_drain(100, "reset_mid");
  endtask

  task automatic test_pend_count();
    int c0;
    int expect_n;
    do_reset();
    c0 = crossings;
    chan_en = 1'b0;
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req = 4'b0010;
      @(negedge clk);
      req = '0;
      @(negedge clk);
    end
`ifdef SYNC_PULSE_ARBITER_PEND_COUNT_EN
    expect_n = 3;
`else
    expect_n = 1;
`endif
    for (int i = 0; i < expect_n; i++) q.push_back(1);
    checks++;
    if (pending !== 4'b0010 || crossings != c0) begin
      errors++;
      $display("FAIL pend_hold pending=%b crossings=%0d required 0010 0", pending, crossings - c0);
    end
    busy_force = 1'b0;
    chan_en = 1'b1;
    wait_drain(200, "pend_count");
    checks++;
    if (crossings - c0 != expect_n) begin
      errors++;
      $display("FAIL pend_count crossings=%0d required %0d", crossings - c0, expect_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    req = '0;
    test_reset();
    test_single();
    test_all();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    test_pend_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
